// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_pkg : data width, TX queue state type and default frame length    |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_W               = 8;
  localparam int DEFAULT_FRAME_CYCLES = 5208;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_q_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_queue_if : host write side and transmitter side of the queue  |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
interface uart_tx_queue_if #(
  parameter int DEPTH = 4
);

  logic                          wr_en;
  logic [uart_pkg::DATA_W-1:0]   wr_data;
  logic                          clr_overflow;
  logic [uart_pkg::DATA_W-1:0]   tx_data;
  logic                          tx_start;
  logic                          busy;
  logic                          full;
  logic                          empty;
  logic [$clog2(DEPTH):0]        count;
  logic                          overflow;

  modport master (
    output wr_en, wr_data, clr_overflow,
    input  tx_data, tx_start, busy, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow,
    output tx_data, tx_start, busy, full, empty, count, overflow
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_sync_fifo : show-ahead circular FIFO; a push while full is taken  |
// |                  only if a pop frees the slot on the same edge         |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    push,
  input  wire logic                    pop,
  input  wire logic [DATA_W-1:0]       din,
  output logic      [DATA_W-1:0]       dout,
  output logic      [$clog2(DEPTH):0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_full) || w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_full);
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_queue : byte queue feeding a handshake-less UART transmitter,  |
// |                 frames paced by internal frame and gap counters        |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
  parameter int GAP_CYCLES   = 0
) (
  input wire logic          clk,
  input wire logic          reset,
  uart_tx_queue_if.slave    bus
);

  localparam int c_frame_w = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int c_gap_w   = (GAP_CYCLES > 0)   ? $clog2(GAP_CYCLES + 1) : 1;

  tx_q_state_e            r_state;
  logic [DATA_W-1:0]      r_tx_data;
  logic                   r_tx_start;
  logic                   r_busy;
  logic                   r_overflow;
  logic [c_frame_w-1:0]   r_frame_cnt;
  logic [c_gap_w-1:0]     r_gap_cnt;

  logic [DATA_W-1:0]      w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_drop;

  assign w_pop  = (r_state == IDLE) && !w_empty;
  assign w_drop = bus.wr_en && w_full && !w_pop;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .pop   (w_pop),
    .din   (bus.wr_data),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_tx_data   <= w_head;
            r_tx_start  <= 1'b1;
            r_frame_cnt <= c_frame_w'(FRAME_CYCLES - 1);
            r_busy      <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (r_frame_cnt == '0) begin
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= c_gap_w'(GAP_CYCLES - 1);
              r_state   <= GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // A dropped write outranks a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_overflow <= 1'b0;
    else if (w_drop)           r_overflow <= 1'b1;
    else if (bus.clr_overflow) r_overflow <= 1'b0;
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.busy     = r_busy;
  assign bus.count    = w_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_tx_queue : two queue instances (gap 3 and gap 0) checked each  |
// |                    cycle against a time-budget queue model             |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_uart_tx_queue;

  localparam int FR = 10;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_overflow = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH(DP)) bus0 ();
  uart_tx_queue_if #(.DEPTH(DP)) bus1 ();

  assign bus0.wr_en = wr_en;  assign bus0.wr_data = wr_data;  assign bus0.clr_overflow = clr_overflow;
  assign bus1.wr_en = wr_en;  assign bus1.wr_data = wr_data;  assign bus1.clr_overflow = clr_overflow;

  uart_tx_queue #(.DEPTH(DP), .FRAME_CYCLES(FR), .GAP_CYCLES(3)) dut0 (
    .clk (clk), .reset (reset), .bus (bus0)
  );
  uart_tx_queue #(.DEPTH(DP), .FRAME_CYCLES(FR), .GAP_CYCLES(0)) dut1 (
    .clk (clk), .reset (reset), .bus (bus1)
  );

  wire [15:0] obs0 = {bus0.tx_data, bus0.tx_start, bus0.busy, bus0.full, bus0.empty, bus0.count, bus0.overflow};
  wire [15:0] obs1 = {bus1.tx_data, bus1.tx_start, bus1.busy, bus1.full, bus1.empty, bus1.count, bus1.overflow};

  // Model: a shift-array byte queue plus a cycle budget that must run out before the next pop.
  int         gap_of [2] = '{3, 0};
  logic [7:0] mq     [2][DP];
  int         mcnt   [2];
  int         cool   [2];
  logic [7:0] mtd    [2];
  bit         mst    [2];
  bit         mov    [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; cool[d] = 0; mtd[d] = 8'h00; mst[d] = 1'b0; mov[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d);
    bit pop, drop;
    pop  = (cool[d] == 0) && (mcnt[d] > 0);
    drop = wr_en && (mcnt[d] == DP) && !pop;
    if (pop) begin
      mtd[d] = mq[d][0];
      for (int i = 0; i < DP - 1; i++) mq[d][i] = mq[d][i+1];
      mcnt[d]--;
      cool[d] = FR + gap_of[d];
      mst[d]  = 1'b1;
    end else begin
      mst[d] = 1'b0;
      if (cool[d] > 0) cool[d]--;
    end
    if (wr_en && !drop) begin
      mq[d][mcnt[d]] = wr_data;
      mcnt[d]++;
    end
    if (drop)              mov[d] = 1'b1;
    else if (clr_overflow) mov[d] = 1'b0;
  endtask

  function automatic logic [15:0] expected(input int d);
    logic [2:0] c;
    c = 3'(mcnt[d]);
    return {mtd[d], mst[d], cool[d] > 0, mcnt[d] == DP, mcnt[d] == 0, c, mov[d]};
  endfunction

  task automatic check(input string tag);
    logic [15:0] e0, e1;
    e0 = expected(0);
    e1 = expected(1);
    vectors++;
    assert (obs0 === e0) else begin
      miscompares++;
      $error("FAIL %s dut0: observed %h expected %h", tag, obs0, e0);
    end
    vectors++;
    assert (obs1 === e1) else begin
      miscompares++;
      $error("FAIL %s dut1: observed %h expected %h", tag, obs1, e1);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check(tag);
  endtask

  task automatic write_byte(input logic [7:0] b, input string tag);
    wr_en = 1'b1;
    wr_data = b;
    step(tag);
    wr_en = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();

    // Reset held with a write request present
    #2 reset = 1'b0;
    wr_en = 1'b1; wr_data = 8'hEE;
    #1 check("reset_async");
    for (int i = 0; i < 4; i++) step("reset_hold");
    wr_en = 1'b0;
    #3 reset = 1'b1;

    // Single byte
    write_byte(8'hA5, "single_wr");
    for (int i = 0; i < 20; i++) step("single_run");

    // Burst pacing
    write_byte(8'h11, "burst_wr");
    write_byte(8'h22, "burst_wr");
    write_byte(8'h33, "burst_wr");
    for (int i = 0; i < 50; i++) step("burst_run");

    // Overflow: first byte occupies SEND, next five hit a depth-4 queue
    write_byte(8'h50, "ovf_first");
    step("ovf_gap");
    for (int i = 1; i <= 5; i++) write_byte(8'h50 + 8'(i), "ovf_wr");
    step("ovf_hold");
    clr_overflow = 1'b1;
    step("ovf_clr");
    clr_overflow = 1'b0;
    for (int i = 0; i < 80; i++) step("ovf_drain");

    // Write landing on the pop edge of a full queue
    write_byte(8'hC0, "wp_first");
    for (int i = 1; i <= 4; i++) write_byte(8'hC0 + 8'(i), "wp_fill");
    guard = 0;
    while (!(cool[0] == 0 && mcnt[0] == DP) && guard < 100) begin
      step("wp_wait");
      guard++;
    end
    vectors++;
    assert (guard < 100) else begin
      miscompares++;
      $error("FAIL wp_timeout: observed %0d cycles expected < 100", guard);
    end
    write_byte(8'hC5, "wp_edge");
    for (int i = 0; i < 90; i++) step("wp_drain");

    // Reset in the middle of a frame
    write_byte(8'h71, "rst_wr");
    write_byte(8'h72, "rst_wr");
    write_byte(8'h73, "rst_wr");
    for (int i = 0; i < 4; i++) step("rst_send");
    #3 reset = 1'b0;
    model_reset();
    #1 check("rst_mid");
    step("rst_hold");
    #3 reset = 1'b1;
    for (int i = 0; i < 30; i++) step("rst_after");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      wr_en        = ($urandom_range(0, 3) == 0);
      wr_data      = 8'($urandom);
      clr_overflow = ($urandom_range(0, 15) == 0);
      step("random");
    end
    wr_en = 1'b0;
    clr_overflow = 1'b0;
    for (int i = 0; i < 80; i++) step("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side byte queue that sits directly upstream of the UART transmitter. Accepts bytes from the host/bus side through a write strobe, buffers them in a small FIFO, and presents them one at a time on `tx_data` with a single-cycle `tx_start` strobe. The UART transmitter exposes no busy/done handshake, so each frame is paced by an internal frame-length counter that keeps `tx_data` stable for the whole serial frame.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `FRAME_CYCLES`, 5208: clocks per complete serial frame (start + data + parity + stop); at least 1.
- `GAP_CYCLES`, 0: extra idle clocks inserted after each frame; at least 0.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push `wr_data` on this edge.
- `wr_data` in 8: byte to queue.
- `clr_overflow` in 1: clears the sticky `overflow` flag.
- `tx_data` out 8: byte for the transmitter; held stable from `tx_start` until the frame ends.
- `tx_start` out 1: one-clock strobe that launches a frame.
- `busy` out 1: high in SEND and GAP.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out $clog2(DEPTH)+1: number of bytes queued.
- `overflow` out 1: sticky; set on a write while full.

## Operation
- Reset values:
  - state = IDLE.
  - `tx_data` = 8'h00, `tx_start` = 0, `busy` = 0.
  - `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0.
  - FIFO pointers = 0.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH.
- Writes:
  - A write with `full` low is stored and increments `count`.
  - A write with `full` high is dropped and sets `overflow`, except in the simultaneous case below.
- Simultaneous write and pop:
  - Both happen and `count` is unchanged.
  - This also applies when `full` is high, because the pop frees a slot in the same edge: the write is accepted and `overflow` is not set.
- `overflow` handling:
  - `clr_overflow` clears `overflow`.
  - If `clr_overflow` coincides with a dropped write, the set wins.
- FSM states: IDLE, SEND, GAP.
  - **IDLE**: when `empty` is low, on the next edge: `tx_data` <= FIFO head, pop, `tx_start` <= 1, frame counter <= FRAME_CYCLES-1, go to SEND.
  - **SEND**: `tx_start` returns to 0 after one cycle. The frame counter decrements each edge. When it reaches 0: if GAP_CYCLES > 0, load the gap counter with GAP_CYCLES-1 and go to GAP; otherwise go to IDLE.
  - **GAP**: the gap counter decrements. At 0, go to IDLE.
- `tx_data` keeps its last value in IDLE. It is never changed except on a pop.
- `busy` is a registered decode of the state (SEND or GAP).

## Timing
- Write-to-start latency:
  - A write on edge N into an idle, empty queue makes `empty` low after N.
  - `tx_start` and the new `tx_data` appear after edge N+1.
- `tx_start` is high for exactly one cycle per frame.
- Frame spacing: with the queue non-empty, consecutive `tx_start` pulses are exactly FRAME_CYCLES + GAP_CYCLES + 1 clocks apart.
- `tx_data` is constant for at least FRAME_CYCLES + GAP_CYCLES + 1 cycles after each `tx_start`.
- Write status: `count`, `full` and `empty` update on the edge that performs the write/pop; no combinational path from `wr_en`.
- Reset mid-frame (`reset` low at any time):
  - All outputs return immediately to their reset values.
  - Queued bytes are discarded.
  - The frame in progress is abandoned; the transmitter is allowed to emit a truncated frame.
- Counter widths: $clog2(FRAME_CYCLES) and $clog2(GAP_CYCLES+1), minimum 1 bit each.

## Structure
- Shared package `uart_pkg`:
  - `DATA_W` = 8.
  - The state enum `tx_q_state_e` {IDLE, SEND, GAP}.
  - A default `FRAME_CYCLES` constant shared with the UART baud settings.
- Sub-module `uart_sync_fifo` (parameters DATA_W, DEPTH):
  - Ports: push, pop, din, dout (head, show-ahead), count, full, empty.
- The top of `uart_tx_queue` holds the FSM, the counters and the overflow logic.

## Test plan
- **Reset**: hold `reset` low with `wr_en`=1 → `tx_data`=00, `tx_start`=0, `busy`=0, `count`=0, `empty`=1, `overflow`=0 throughout.
- **Single byte**: FRAME_CYCLES=10, GAP_CYCLES=0; write A5 at edge N → one-cycle `tx_start` after N+1, `tx_data`=A5; `busy` high 10 cycles; then IDLE with `tx_data` still A5.
- **Burst pacing**: write 11,22,33 on consecutive edges, FRAME_CYCLES=10, GAP_CYCLES=3 → `tx_start` pulses 14 clocks apart; bytes appear in order 11,22,33; `empty`=1 after the third pop.
- **Overflow**: DEPTH=4, blocked in SEND with a long frame; write 5 bytes → `full`=1 after the 4th, 5th byte dropped, `overflow`=1; `clr_overflow` → 0; later output order is the first four bytes only.
- **Write and pop together**: queue full, write timed to the IDLE pop edge → `count` stays 4, `overflow` stays 0, the written byte is transmitted last.
- **Reset mid-SEND**: 3 bytes queued, assert `reset` halfway through the first frame → all outputs at reset values; after release no `tx_start` until a new write.
